// File: rtl/fact_engine.sv
// -----------------------------------------------------------------------------
// fact_engine
//   Iterative factorial engine with a go/done handshake. Computes n! by
//   multiplying a product register by a down-counter (n, n-1, ..., 2), one
//   multiply per two cycles (CHECK then MUL). Overflow aborts the run and
//   forces the result to all-ones (SAT=1) or zero (SAT=0).
//
// Parameters
//   N_W  width of operand n
//   P_W  width of product / result
//   SAT  overflow policy: 1 -> result all-ones, 0 -> result zero
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous reset, active-high
//   go      start request, sampled only in IDLE
//   n       operand, captured on the edge that accepts go
//   busy    high in every state except IDLE
//   done    one-cycle completion pulse (DONE or ERR)
//   err     high with done when the run overflowed
//   result  registered result, held until the next completion
// -----------------------------------------------------------------------------
module fact_engine #(
  parameter int N_W = 4,
  parameter int P_W = 32,
  parameter bit SAT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [P_W-1:0] result
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    DONE,
    ERR
  } state_t;

  localparam logic [P_W-1:0] OVF_VAL = SAT ? {P_W{1'b1}} : {P_W{1'b0}};

  state_t             state, state_nx;
  logic [N_W-1:0]     cnt;
  logic [P_W-1:0]     prod;
  logic [P_W+N_W-1:0] full;
  logic               ovf;

  // Full-width product: cnt < 2^N_W, so prod*cnt always fits in P_W+N_W bits
  // and any nonzero upper bit means the P_W-bit result would be truncated.
  assign full = {{N_W{1'b0}}, prod} * {{P_W{1'b0}}, cnt};
  assign ovf  = |full[P_W+N_W-1:P_W];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and Moore output decode.
  // NOTE: every output is given a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nx = CHECK;
      end
      CHECK: state_nx = (cnt <= N_W'(1)) ? DONE : MUL;
      MUL:   state_nx = ovf ? ERR : CHECK;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        done     = 1'b1;
        err      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: counter, product and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      prod   <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            cnt  <= n;
            prod <= P_W'(1);
          end
        end
        CHECK: begin
          if (cnt <= N_W'(1)) result <= prod;
        end
        MUL: begin
          if (ovf) begin
            result <= OVF_VAL;
          end else begin
            prod <= full[P_W-1:0];
            cnt  <= cnt - N_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_engine.sv
// -----------------------------------------------------------------------------
// tb_fact_engine
//   Self-checking bench for fact_engine. Two instances share stimulus: one
//   with SAT=1, one with SAT=0. Directed table vectors, hand-written corner
//   sequences (back-to-back runs, ignored go/n while busy, async reset), then
//   randomized runs checked against an arithmetic factorial model.
// -----------------------------------------------------------------------------
module tb_fact_engine;

  localparam int N_W = 4;
  localparam int P_W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           go  = 1'b0;
  logic [N_W-1:0] n   = '0;
  logic           busy1, done1, err1;
  logic           busy0, done0, err0;
  logic [P_W-1:0] result1, result0;

  int tests_run = 0;
  int tests_failed = 0;

  // Last completed result of each instance, expected to be held between runs.
  logic [P_W-1:0] prev1 = '0;
  logic [P_W-1:0] prev0 = '0;

  always #5 clk = ~clk;

  fact_engine #(.N_W(N_W), .P_W(P_W), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy1), .done(done1), .err(err1), .result(result1)
  );

  fact_engine #(.N_W(N_W), .P_W(P_W), .SAT(1'b0)) dut_zero (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy0), .done(done0), .err(err0), .result(result0)
  );

  typedef struct {
    int          nv;
    logic [31:0] exp_res;  // SAT=1 result
    bit          exp_err;
    int          exp_cyc;  // cycle of done, go accepted at end of cycle 0
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: n! by plain 64-bit arithmetic, aborting on the first product
  // that no longer fits in 32 bits. Multiply number i lands in cycle 2i.
  task automatic model(input int nv, output logic [31:0] r, output bit e, output int cyc);
    longint unsigned p = 1;
    int i = 0;
    e   = 1'b0;
    cyc = 2;
    for (int k = nv; k >= 2; k--) begin
      i++;
      if (p * longint'(k) > 64'hFFFF_FFFF) begin
        e   = 1'b1;
        cyc = 2 * i + 1;
        break;
      end
      p   = p * longint'(k);
      cyc = 2 * i + 2;
    end
    r = e ? 32'hFFFF_FFFF : p[31:0];
  endtask

  // One run: go with n=nv at cycle 0, then check every cycle through done.
  // hold_go keeps go high through the run (including the DONE cycle).
  // perturb pulses go with n=3 at cycle 4 and changes n to 9 at cycle 6.
  task automatic run(input string name, input int nv, input logic [31:0] exp_r,
                     input bit exp_e, input int exp_cyc, input bit hold_go,
                     input bit perturb);
    logic [31:0] exp_r0;
    exp_r0 = exp_e ? 32'h0 : exp_r;
    @(negedge clk);
    go = 1'b1;
    n  = N_W'(nv);
    @(posedge clk);
    #1;
    if (!hold_go) go = 1'b0;
    for (int c = 1; c <= exp_cyc; c++) begin
      @(negedge clk);
      check({name, " busy"}, {62'b0, busy1, busy0}, 64'h3);
      check({name, " done"}, {62'b0, done1, done0}, (c == exp_cyc) ? 64'h3 : 64'h0);
      check({name, " err"},  {62'b0, err1,  err0},  (c == exp_cyc && exp_e) ? 64'h3 : 64'h0);
      check({name, " result_sat"},  64'(result1), (c == exp_cyc) ? 64'(exp_r)  : 64'(prev1));
      check({name, " result_zero"}, 64'(result0), (c == exp_cyc) ? 64'(exp_r0) : 64'(prev0));
      if (perturb) begin
        if (c == 4) begin go = 1'b1; n = 4'd3; end
        if (c == 5) go = 1'b0;
        if (c == 6) n = 4'd9;
      end
    end
    prev1 = exp_r;
    prev0 = exp_r0;
  endtask

  // One idle cycle after a run: engine back in IDLE, result still held.
  task automatic idle(input string name);
    @(negedge clk);
    check({name, " idle busy"}, {62'b0, busy1, busy0}, 64'h0);
    check({name, " idle done"}, {62'b0, done1, done0}, 64'h0);
    check({name, " idle hold"}, {result1, result0}, {prev1, prev0});
    go = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] mr;
    bit          me;
    int          mc;
    int          nv;
    int          seen_done;

    vecs.push_back('{5,  32'd120,        1'b0, 10});
    vecs.push_back('{0,  32'd1,          1'b0, 2});
    vecs.push_back('{1,  32'd1,          1'b0, 2});
    vecs.push_back('{2,  32'd2,          1'b0, 4});
    vecs.push_back('{12, 32'd479001600,  1'b0, 24});
    vecs.push_back('{13, 32'hFFFF_FFFF,  1'b1, 25});
    vecs.push_back('{14, 32'hFFFF_FFFF,  1'b1, 23});
    vecs.push_back('{15, 32'hFFFF_FFFF,  1'b1, 21});
    vecs.push_back('{3,  32'd6,          1'b0, 6});

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset outputs", {60'b0, busy1, done1, err1, busy0}, 64'h0);
    check("reset result", {result1, result0}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle", {61'b0, busy1, done1, err1}, 64'h0);

    // Directed table.
    foreach (vecs[i]) begin
      run($sformatf("vec n=%0d", vecs[i].nv), vecs[i].nv, vecs[i].exp_res,
          vecs[i].exp_err, vecs[i].exp_cyc, 1'b0, 1'b0);
      idle($sformatf("vec n=%0d", vecs[i].nv));
    end

    // Back-to-back n=0 then n=1, go held high through the first DONE cycle.
    run("b2b n=0", 0, 32'd1, 1'b0, 2, 1'b1, 1'b0);
    run("b2b n=1", 1, 32'd1, 1'b0, 2, 1'b0, 1'b0);
    idle("b2b");

    // go/n changes while busy must not disturb an n=7 run.
    run("ignore n=7", 7, 32'd5040, 1'b0, 14, 1'b0, 1'b1);
    idle("ignore");

    // Asynchronous reset in the middle of cycle 7 of an n=10 run.
    @(negedge clk);
    go = 1'b1;
    n  = 4'd10;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst outputs", {58'b0, busy1, done1, err1, busy0, done0, err0}, 64'h0);
    check("async rst result", {result1, result0}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done1 || done0 || busy1 || busy0) seen_done++;
    end
    check("no activity after rst", 64'(seen_done), 64'h0);
    prev1 = '0;
    prev0 = '0;
    run("after rst n=4", 4, 32'd24, 1'b0, 8, 1'b0, 1'b0);
    idle("after rst");

    // Randomized runs against the arithmetic model.
    for (int t = 0; t < 40; t++) begin
      nv = int'($urandom_range(0, 15));
      model(nv, mr, me, mc);
      run($sformatf("rand%0d n=%0d", t, nv), nv, mr, me, mc, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) idle($sformatf("rand%0d", t));
    end
    idle("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fact_engine.md
Name: fact_engine

Overview:
Parametrised, self-contained factorial engine: integrated control FSM, down-counter, product register and single-cycle multiplier. Computes n! for an N_W-bit operand into a P_W-bit result. Adds overflow detection, optional saturation, a busy flag and a held result register. Sits on the accelerator bus as a go/done slave; the host drives n and go, then samples result/err on done.

Parameters:
N_W, 4, width of operand n (max n = 2^N_W - 1)
P_W, 32, width of product/result register
SAT, 1, overflow policy: 1 -> result forced all-ones; 0 -> result forced zero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
go  input  1  start request; sampled only in IDLE
n  input  N_W  operand; captured on the edge that accepts go
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse (DONE or ERR state)
err  output  1  high with done when overflow occurred; low otherwise
result  output  P_W  registered result; held until next completion

Behaviour:
- Reset (async, any state, mid-operation included): state IDLE, cnt=0, prod=0, result=0; busy=0, done=0, err=0. No completion pulse after reset release.
- States: IDLE, CHECK, MUL, DONE, ERR. done/err/busy decode from the state (Moore); result is a register.
- IDLE: go=1 at edge -> cnt<=n, prod<=1, next CHECK. go=0 -> stay.
- CHECK: cnt<=1 -> result<=prod, next DONE. Otherwise next MUL.
- MUL: full = prod * cnt, computed at P_W+N_W bits. Upper N_W bits nonzero -> result <= SAT ? all-ones : 0, next ERR. Else prod<=full[P_W-1:0], cnt<=cnt-1, next CHECK.
- DONE: done=1, err=0, next IDLE.
- ERR: done=1, err=1, next IDLE.
- Product order is descending (n, n-1, ..., 2). Overflow is checked on every MUL; the first overflowing multiply aborts.
- go is ignored while busy, including the DONE/ERR cycle. A new go is accepted at the earliest in the cycle after done.
- n is sampled only on acceptance; later changes to n do not affect the run in progress.
- Latency, with go accepted on edge at end of cycle 0:
  - n=0 or n=1: done in cycle 2, result=1.
  - n>=2 without overflow: done in cycle 2n.
  - Overflow: done+err in the cycle after the overflowing MUL.
- result changes only on the edge entering DONE or ERR, and holds otherwise, including through IDLE and the next run.

Test Plan:
- Defaults. Reset, then go=1 for one cycle with n=5 -> busy=1 during cycles 1..10; done=1, err=0 in cycle 10 only; result=120 from cycle 10 onward.
- n=0, then n=1 (back-to-back, second go in the cycle after done) -> each run gives done in cycle 2 after its go, result=1, err=0; go held high during the DONE cycle starts no extra run.
- n=12 -> done in cycle 24, result=479001600, err=0.
- n=13, SAT=1 -> overflow on the multiply by 2 (3113510400*2); done=err=1 in cycle 25; result=0xFFFFFFFF. Repeat with SAT=0 -> result=0.
- Start n=7; pulse go with n=3 at cycle 4 and change n to 9 at cycle 6 -> both ignored; done in cycle 14, result=5040.
- Start n=10; assert rst asynchronously mid-cycle 7 -> busy/done/err/result drop to 0 immediately, no done pulse after release; then n=4 -> result=24 in cycle 8 of the new run.
